// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared segment constants and scan-state types for the snake display
package snake_pkg;

   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   typedef logic [7:0] seg_t;

   typedef enum logic {
      BLANK = 1'b0,
      ON    = 1'b1
   } scan_state_t;

endpackage

// File: rtl/seg_dbuf.sv
// rtl/seg_dbuf.sv - front/back segment double buffer with write port and front read port
module seg_dbuf
   import snake_pkg::*;
#(
   parameter  int N_DIGITS = 6,
   localparam int DW       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [DW-1:0] wr_digit,
   input  logic [7:0]    wr_data,
   input  logic          swap,
   input  logic [DW-1:0] rd_digit,
   output logic [7:0]    rd_data
);

   localparam logic [DW-1:0] LAST_DIG = DW'(N_DIGITS - 1);

   seg_t buf0 [N_DIGITS];
   seg_t buf1 [N_DIGITS];
   logic sel;
   logic wr_ok;

   assign wr_ok = wr_en && (wr_digit <= LAST_DIG);

   // sel=0: buf0 is front, buf1 is back. Writes use the pre-toggle sel, so a
   // write on the swap edge lands in the buffer that is about to become front.
   always_ff @(posedge clk) begin
      if (rst) begin
         sel <= 1'b0;
         for (int i = 0; i < N_DIGITS; i++) begin
            buf0[i] <= '0;
            buf1[i] <= '0;
         end
      end else begin
         if (wr_ok && sel)
            buf0[wr_digit] <= wr_data;
         if (wr_ok && !sel)
            buf1[wr_digit] <= wr_data;
         if (swap)
            sel <= ~sel;
      end
   end

   assign rd_data = sel ? buf1[rd_digit] : buf0[rd_digit];

endmodule

// File: rtl/seg_frame_scanner.sv
// rtl/seg_frame_scanner.sv - multiplexed 7-segment scanner with frame-boundary buffer swap
module seg_frame_scanner
   import snake_pkg::*;
#(
   parameter  int N_DIGITS   = 6,
   parameter  int ON_CLKS    = 1000,
   parameter  int BLANK_CLKS = 50,
   parameter  int ACTIVE_LOW = 1,
   localparam int DW         = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic [DW-1:0]       wr_digit,
   input  logic [7:0]          wr_data,
   input  logic                swap_req,
   output logic                swap_done,
   output logic                segA,
   output logic                segB,
   output logic                segC,
   output logic                segD,
   output logic                segE,
   output logic                segF,
   output logic                segG,
   output logic                segDP,
   output logic [N_DIGITS-1:0] dig_en
);

   localparam int              CMAX      = (ON_CLKS > BLANK_CLKS) ? ON_CLKS : BLANK_CLKS;
   localparam int              CW        = $clog2(CMAX + 1);
   localparam logic [CW-1:0]   ON_LIM    = CW'(ON_CLKS);
   localparam logic [CW-1:0]   BLANK_LIM = CW'(BLANK_CLKS);
   localparam logic [DW-1:0]   LAST_DIG  = DW'(N_DIGITS - 1);
   localparam logic            POL       = (ACTIVE_LOW != 0);

   scan_state_t         state, state_n;
   logic [CW-1:0]       cnt, cnt_n;
   logic [DW-1:0]       dig, dig_n;
   logic                pending, pending_n;
   logic                frame_edge, do_swap;
   logic [7:0]          front_data;
   seg_t                seg_q;
   logic [N_DIGITS-1:0] en_q;
   logic                swap_done_q;

   // Front buffer is read at the next digit index so the lit pattern is
   // registered on the same edge the FSM enters ON.
   seg_dbuf #(.N_DIGITS(N_DIGITS)) u_dbuf (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_digit (wr_digit),
      .wr_data  (wr_data),
      .swap     (do_swap),
      .rd_digit (dig_n),
      .rd_data  (front_data)
   );

   // cnt counts cycles already shown in the current state; it leaves reset
   // at 0 so the first blank phase still lasts BLANK_CLKS visible cycles.
   always_comb begin
      state_n    = state;
      cnt_n      = cnt + CW'(1);
      dig_n      = dig;
      frame_edge = 1'b0;
      case (state)
         BLANK: begin
            if (cnt == BLANK_LIM) begin
               state_n = ON;
               cnt_n   = CW'(1);
            end
         end
         ON: begin
            if (cnt == ON_LIM) begin
               state_n = BLANK;
               cnt_n   = CW'(1);
               if (dig == LAST_DIG) begin
                  dig_n      = '0;
                  frame_edge = 1'b1;
               end else begin
                  dig_n = dig + DW'(1);
               end
            end
         end
         default: ;
      endcase
      do_swap   = frame_edge & pending;
      pending_n = (pending & ~frame_edge) | swap_req;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= BLANK;
         cnt         <= '0;
         dig         <= '0;
         pending     <= 1'b0;
         swap_done_q <= 1'b0;
         seg_q       <= '0;
         en_q        <= '0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         dig         <= dig_n;
         pending     <= pending_n;
         swap_done_q <= do_swap;
         seg_q       <= (state_n == ON) ? front_data : '0;
         en_q        <= (state_n == ON) ? (N_DIGITS'(1) << dig_n) : '0;
      end
   end

   assign swap_done = swap_done_q;
   assign segA      = seg_q[SEG_A]  ^ POL;
   assign segB      = seg_q[SEG_B]  ^ POL;
   assign segC      = seg_q[SEG_C]  ^ POL;
   assign segD      = seg_q[SEG_D]  ^ POL;
   assign segE      = seg_q[SEG_E]  ^ POL;
   assign segF      = seg_q[SEG_F]  ^ POL;
   assign segG      = seg_q[SEG_G]  ^ POL;
   assign segDP     = seg_q[SEG_DP] ^ POL;
   assign dig_en    = en_q ^ {N_DIGITS{POL}};

endmodule

// File: tb/tb_seg_frame_scanner.sv
// tb/tb_seg_frame_scanner.sv - frame-by-frame directed check of seg_frame_scanner
module tb_seg_frame_scanner;

   logic       clk;
   logic       rst;
   logic       wr_en;
   logic [2:0] wr_digit;
   logic [7:0] wr_data;
   logic       swap_req;
   logic       swap_done;
   logic       segA, segB, segC, segD, segE, segF, segG, segDP;
   logic [5:0] dig_en;
   logic [7:0] seg_bus;

   int compared   = 0;
   int mismatched = 0;
   int t;

   logic [29:0] plan_req;
   int          plan_wpos;
   logic [2:0]  plan_wd;
   logic [7:0]  plan_wv;

   typedef struct {
      string       nm;
      logic [2:0]  wd;
      logic [7:0]  wv;
      int          wpos;
      logic [29:0] req;
      logic        done;
      logic [47:0] shown;
   } vec_t;

   vec_t vecs [13];

   localparam logic [47:0] ZERO = 48'h00_00_00_00_00_00;
   localparam logic [47:0] BV1  = 48'h06_00_00_00_00_3F;
   localparam logic [47:0] AV1  = 48'h00_00_00_FF_00_00;
   localparam logic [47:0] BV2  = 48'h06_00_00_00_40_3F;

   seg_frame_scanner #(
      .N_DIGITS   (6),
      .ON_CLKS    (4),
      .BLANK_CLKS (1),
      .ACTIVE_LOW (1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_digit  (wr_digit),
      .wr_data   (wr_data),
      .swap_req  (swap_req),
      .swap_done (swap_done),
      .segA      (segA),
      .segB      (segB),
      .segC      (segC),
      .segD      (segD),
      .segE      (segE),
      .segF      (segF),
      .segG      (segG),
      .segDP     (segDP),
      .dig_en    (dig_en)
   );

   assign seg_bus = {segDP, segG, segF, segE, segD, segC, segB, segA};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      t++;
   endtask

   task automatic check_idle(input string nm);
      compared++;
      if ({dig_en, seg_bus, swap_done} !== {6'h3F, 8'hFF, 1'b0}) begin
         mismatched++;
         $display("FAIL %s: got dig_en=%b seg=%h swap_done=%b, want dig_en=111111 seg=ff swap_done=0",
                  nm, dig_en, seg_bus, swap_done);
      end
   endtask

   // Cycle t of a frame: position 0,5,10.. is blank, otherwise digit pos/5 is lit.
   task automatic check_cycle(input string nm, input logic [47:0] shown, input logic exp_done);
      int         pos;
      int         d;
      logic [5:0] exp_dig;
      logic [7:0] exp_seg;
      pos     = t % 30;
      exp_dig = 6'h3F;
      exp_seg = 8'hFF;
      if (pos % 5 != 0) begin
         d       = pos / 5;
         exp_dig = ~(6'b000001 << d);
         exp_seg = ~shown[d*8 +: 8];
      end
      compared++;
      if ({dig_en, seg_bus, swap_done} !== {exp_dig, exp_seg, exp_done}) begin
         mismatched++;
         $display("FAIL %s t=%0d: got dig_en=%b seg=%h swap_done=%b, want dig_en=%b seg=%h swap_done=%b",
                  nm, t, dig_en, seg_bus, swap_done, exp_dig, exp_seg, exp_done);
      end
   endtask

   task automatic run_frame(input string nm, input logic [47:0] shown, input logic exp_done,
                            input int ncyc);
      for (int k = 0; k < ncyc; k++) begin
         wr_en    = (k == plan_wpos);
         wr_digit = plan_wd;
         wr_data  = plan_wv;
         swap_req = plan_req[k];
         step();
         wr_en    = 1'b0;
         swap_req = 1'b0;
         check_cycle(nm, shown, (k == 0) ? exp_done : 1'b0);
      end
   endtask

   task automatic clear_plan();
      plan_req  = '0;
      plan_wpos = -1;
      plan_wd   = '0;
      plan_wv   = '0;
   endtask

   initial begin
      rst      = 1'b1;
      wr_en    = 1'b0;
      wr_digit = '0;
      wr_data  = '0;
      swap_req = 1'b0;
      t        = 0;
      clear_plan();

      vecs[0]  = '{"reset_f0",   3'd0, 8'h00, -1, 30'h0,       1'b0, ZERO};
      vecs[1]  = '{"reset_f1",   3'd0, 8'h00, -1, 30'h0,       1'b0, ZERO};
      vecs[2]  = '{"wr_d0",      3'd0, 8'h3F,  3, 30'h0,       1'b0, ZERO};
      vecs[3]  = '{"wr_d5_req",  3'd5, 8'h06,  7, 30'h400,     1'b0, ZERO};
      vecs[4]  = '{"basic_show", 3'd2, 8'hFF, 12, 30'h0,       1'b1, BV1};
      vecs[5]  = '{"isolate_1",  3'd0, 8'h00, -1, 30'h0,       1'b0, BV1};
      vecs[6]  = '{"isolate_2",  3'd0, 8'h00, -1, 30'h0,       1'b0, BV1};
      vecs[7]  = '{"merge_reqs", 3'd0, 8'h00, -1, 30'h2000204, 1'b0, BV1};
      vecs[8]  = '{"merge_swap", 3'd0, 8'h00, -1, 30'h0,       1'b1, AV1};
      vecs[9]  = '{"merge_once", 3'd0, 8'h00, -1, 30'h8000,    1'b0, AV1};
      vecs[10] = '{"edge_coll",  3'd1, 8'h40,  0, 30'h1,       1'b1, BV2};
      vecs[11] = '{"edge_rearm", 3'd0, 8'h00, -1, 30'h0,       1'b1, AV1};
      vecs[12] = '{"illegal_wr", 3'd7, 8'hAA,  4, 30'h100,     1'b0, AV1};

      step();
      check_idle("reset_state");
      wr_en    = 1'b1;
      wr_digit = 3'd0;
      wr_data  = 8'h55;
      swap_req = 1'b1;
      step();
      wr_en    = 1'b0;
      swap_req = 1'b0;
      check_idle("reset_drops_inputs");
      rst = 1'b0;
      t   = -1;

      for (int i = 0; i < 13; i++) begin
         clear_plan();
         plan_wd   = vecs[i].wd;
         plan_wv   = vecs[i].wv;
         plan_wpos = vecs[i].wpos;
         plan_req  = vecs[i].req;
         run_frame(vecs[i].nm, vecs[i].shown, vecs[i].done, 30);
      end

      // Illegal write left B untouched; then reset mid-ON (digit 2) with a swap pending.
      clear_plan();
      plan_req = 30'h8;
      run_frame("illegal_show", BV2, 1'b1, 13);
      rst      = 1'b1;
      wr_en    = 1'b1;
      wr_digit = 3'd0;
      wr_data  = 8'h55;
      swap_req = 1'b1;
      step();
      wr_en    = 1'b0;
      swap_req = 1'b0;
      check_idle("mid_on_reset");
      step();
      check_idle("reset_hold");
      rst = 1'b0;
      t   = -1;

      clear_plan();
      run_frame("post_rst_f0", ZERO, 1'b0, 30);
      plan_req = 30'h20;
      run_frame("no_stale_swap", ZERO, 1'b0, 30);
      clear_plan();
      run_frame("bufs_cleared", ZERO, 1'b1, 30);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/seg_frame_scanner.md
# seg_frame_scanner

Display-side reader for the snake field. Game logic writes per-digit segment patterns into a back buffer and requests a frame swap. The block scans the front buffer onto a multiplexed common-digit 7-segment display, one digit at a time, with a blanking gap between digits. Swaps take effect only at frame boundaries, so no frame is ever shown half-updated.

## Interface
- `N_DIGITS`, default 6: digits on the display. One digit covers three field columns, so 18 columns give 6 digits.
- `ON_CLKS`, default 1000: cycles each digit is lit; ≥1.
- `BLANK_CLKS`, default 50: cycles with all digits off before each digit; ≥1.
- `ACTIVE_LOW`, default 1: 1 means segment and digit outputs are active-low.
- `clk`  in  1: the single clock.
- `rst`  in  1: reset, synchronous and active-high.
- `wr_en`  in  1: write strobe into the back buffer.
- `wr_digit`  in  $clog2(N_DIGITS): target digit.
- `wr_data`  in  8: segment pattern {DP,G,F,E,D,C,B,A}; 1 means lit.
- `swap_req`  in  1: single-cycle request to publish the back buffer.
- `swap_done`  out  1: one-cycle pulse on the cycle the swap executes.
- `segA`..`segG`, `segDP`  out  1 each: segment drives.
- `dig_en`  out  N_DIGITS: digit enables, one-hot when a digit is lit.

## Operation
- **Buffers.** Two buffers, each `N_DIGITS`×8. A `sel` bit marks which one is the front.
- **Writes.**
  - `wr_en` writes `wr_data` into `back[wr_digit]`.
  - `wr_digit` ≥ `N_DIGITS` is ignored, with no side effects.
- **Swap request.** `swap_req` sets `pending`. Repeated requests before execution merge into one.
- **Scan FSM**, two states, with counter `cnt` and digit index `dig`:
  - BLANK: all outputs inactive. After `BLANK_CLKS` cycles → ON.
  - ON: `dig_en[dig]` active, segments = `front[dig]`. After `ON_CLKS` cycles → BLANK with `dig`+1. `dig` wraps from `N_DIGITS`-1 to 0.
- **Frame boundary** = the ON→BLANK transition from `dig=N_DIGITS-1`. On that edge, if `pending`:
  - toggle `sel`;
  - clear `pending`;
  - pulse `swap_done`.
- **Buffer contents after a swap.** The back buffer holds the previous front contents; nothing is copied. Game logic rewrites every digit before the next request.
- **Simultaneous events:**
  - Write on the swap edge: lands in the pre-swap back buffer, so it is visible in the new frame.
  - `swap_req` on the swap edge: re-arms `pending` for the next frame.
  - `rst` with `wr_en`/`swap_req`: `rst` wins; the inputs are dropped.
- **Polarity.** When `ACTIVE_LOW`=1, all outputs are inverted at the ports. "Inactive" means segments and digits off.

## Timing
- **Reset values:**
  - both buffers = 0;
  - `sel`=0, `pending`=0, state BLANK, `cnt`=0, `dig`=0;
  - `swap_done`=0;
  - all segments and `dig_en` inactive. With `ACTIVE_LOW`=1, every segment output and every `dig_en` bit is 1.
- **Outputs are registered** and change only on `clk` edges.
- **Cycle numbering.** Cycle 0 is the first edge with `rst` low.
  - Digit 0 is lit from cycle `BLANK_CLKS` for exactly `ON_CLKS` cycles.
  - Frame period = `N_DIGITS`·(`BLANK_CLKS`+`ON_CLKS`).
- **Write visibility.** A write made in frame k appears no earlier than frame k+1, and only after a swap.
- **Swap latency.** Worst case is one full frame period + 1 cycle. `swap_done` coincides with the first BLANK cycle of the new frame.
- **Mid-operation reset.** A reset in any state returns everything to reset values on the next edge. A pending swap is discarded.

## Structure
- **Shared package `snake_pkg`:**
  - segment bit-index constants `SEG_A`..`SEG_DP`;
  - the 8-bit segment pattern typedef;
  - scan-state enum {BLANK, ON}.
- **Sub-module `seg_dbuf`:** the double buffer, containing both arrays, the `sel` bit, the write port and a read port.
- **Top** holds the FSM, the counters and the output registers.

## Test plan
All scenarios use `N_DIGITS`=6, `ON_CLKS`=4, `BLANK_CLKS`=1, `ACTIVE_LOW`=1.
- **Reset, no writes:** release `rst` → every output 1 for 60 cycles; `dig_en` steps 111110 → 011111 (digit 0 first), each lit 4 cycles with 1 blank cycle between digits.
- **Basic display:** write digit 0=8'h3F and digit 5=8'h06, then `swap_req` → `swap_done` within 31 cycles; next frame shows `dig_en`=111110 with segments=~8'h3F and `dig_en`=011111 with segments=~8'h06.
- **Write isolation:** write digit 2=8'hFF with no swap → displayed digit 2 stays at its old pattern for 3 frames.
- **Merged requests:** three `swap_req` pulses within one frame → exactly one `swap_done`, and `sel` toggles once.
- **Edge collision:** `swap_req` and a write to digit 1=8'h40 on the swap edge → the new frame shows 8'h40 on digit 1, and a second `swap_done` occurs one frame later.
- **Illegal address and reset:** write to digit 7 → no buffer change. Assert `rst` mid-ON with a swap pending → outputs go inactive next edge, and no `swap_done` follows.
